lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the EX-stage ALU in the single-issue, non-pipelined RV32I core.
- Consumes the ALU result as the effective address and the rs2 value as store data, and performs one load or store on a simple request/ready data-memory bus.
- Performs byte-lane alignment and load sign/zero extension, and asserts busy so the core stalls the PC until the access completes.

Parameters:
- WORD_BITWIDTH, 32, data/address width; fixed at 32 for RV32I, and byte-lane logic assumes 4 lanes.
- STRB_BITWIDTH, 4, byte-strobe width, equal to WORD_BITWIDTH/8.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request from EX; sampled only in IDLE.
- is_load  input  1  operation is a load.
- is_store  input  1  operation is a store.
- funct3  input  3  RV32I size/sign field.
- alu_result  input  WORD_BITWIDTH  effective byte address from the ALU ADD.
- store_data  input  WORD_BITWIDTH  rs2 value, right-aligned.
- mem_req  output  1  bus request, held until mem_ready.
- mem_we  output  1  1 = write.
- mem_addr  output  WORD_BITWIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  output  WORD_BITWIDTH  lane-replicated store data.
- mem_wstrb  output  STRB_BITWIDTH  byte enables; 0 on reads.
- mem_ready  input  1  bus completes the access this cycle; mem_rdata is valid in the same cycle.
- mem_rdata  input  WORD_BITWIDTH  read word.
- busy  output  1  high in REQ and DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned or illegal access.
- load_data  output  WORD_BITWIDTH  extended load result; valid with done and held until the next accept.

Behaviour:
- Reset (async, any state): state=IDLE. mem_req, mem_we, mem_wstrb, busy, done, err, load_data, mem_addr and mem_wdata all go to 0. All outputs are registered or derived from state, so they clear immediately on reset.
- FSM IDLE:
  - Accept happens when start & (is_load ^ is_store).
  - start with neither or both flags set is ignored and produces no done.
  - On accept, register addr, funct3, direction and store_data, then check legality.
  - Illegal load funct3 is 011, 110 or 111; illegal store funct3 is anything other than 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Illegal or misaligned: go to DONE with err=1; no mem_req is issued.
  - Otherwise go to REQ.
- FSM REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_wstrb are stable for the whole state.
  - On mem_ready: capture the extended load result (loads only) and go to DONE.
  - With no mem_ready, wait indefinitely.
- FSM DONE: done=1 for exactly one cycle; err valid; then go to IDLE.
- start is ignored while busy. Minimum latency from accept to done is 2 cycles, plus one cycle per cycle of mem_ready low.
- Store lanes, with o=addr[1:0]:
  - SB: wstrb=4'b0001<<o; wdata is the byte replicated x4.
  - SH: wstrb=4'b0011<<o; wdata is the half replicated x2.
  - SW: wstrb=4'b1111; wdata is store_data.
- Load extraction: shift mem_rdata right by 8*o, then extend.
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW passes the word through.
- Stores leave load_data unchanged except that an accept clears it to 0. Error completions also leave load_data=0.
- A mem_ready asserted outside REQ is ignored.

Test Plan:
- LW addr 0x1000, mem_ready=1 in the first REQ cycle, rdata 0xDEADBEEF -> mem_req for 1 cycle with mem_addr 0x1000, wstrb 0; done at accept+2 with load_data 0xDEADBEEF and err=0.
- LB then LBU at addr 0x2003, rdata 0x80FF1234 -> load_data 0xFFFFFF80, then 0x00000080. LH at 0x2002 with rdata 0x80FF1234 -> 0xFFFF80FF.
- SH addr 0x1002, store_data 0x1234ABCD -> mem_we=1, mem_addr 0x1000, mem_wstrb 4'b1100, mem_wdata 0xABCDABCD. SB at 0x1001 with data 0x000000EE -> wstrb 4'b0010, wdata 0xEEEEEEEE.
- LW at 0x1001; SH at 0x1003; load with funct3=011 -> no mem_req, done and err=1 at accept+1, load_data 0.
- mem_ready low for 3 REQ cycles, with start pulsed during busy -> mem_req and address held stable for 4 cycles, busy high; done at accept+5; exactly one done, and the pulsed start is not accepted.
- Assert rst during REQ -> mem_req, busy and done drop immediately (async); after release the FSM is IDLE and the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: one load/store per request on a req/ready bus.
// Handles byte-lane steering, load extension, alignment and legality errors.
module lsu_mem_stage #(
   parameter int WORD_BITWIDTH = 32,
   parameter int STRB_BITWIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     is_load,
   input  logic                     is_store,
   input  logic [2:0]               funct3,
   input  logic [WORD_BITWIDTH-1:0] alu_result,
   input  logic [WORD_BITWIDTH-1:0] store_data,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [WORD_BITWIDTH-1:0] mem_addr,
   output logic [WORD_BITWIDTH-1:0] mem_wdata,
   output logic [STRB_BITWIDTH-1:0] mem_wstrb,
   input  logic                     mem_ready,
   input  logic [WORD_BITWIDTH-1:0] mem_rdata,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [WORD_BITWIDTH-1:0] load_data
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                   state;
   logic [1:0]               off_q;
   logic [2:0]               f3_q;
   logic                     ld_q;

   logic                     accept;
   logic                     bad_f3;
   logic                     misal;
   logic [1:0]               off;
   logic [STRB_BITWIDTH-1:0] st_strb;
   logic [WORD_BITWIDTH-1:0] st_data;
   logic [WORD_BITWIDTH-1:0] sh;
   logic [WORD_BITWIDTH-1:0] ext;

   always_comb begin
      off    = alu_result[1:0];
      accept = start & (is_load ^ is_store);
      bad_f3 = is_load ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                       : (funct3[2] || funct3[1:0] == 2'b11);
      misal  = (funct3[1:0] == 2'b01 && off[0]) ||
               (funct3[1:0] == 2'b10 && off != 2'b00);
      case (funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << off;
            st_data = {4{store_data[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << off;
            st_data = {2{store_data[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = store_data;
         end
      endcase
   end

   // Extension uses the offset/size latched at accept, not the live inputs.
   always_comb begin
      sh = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ext = {24'd0, sh[7:0]};
         3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ext = {16'd0, sh[15:0]};
         default: ext = sh;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         off_q     <= '0;
         f3_q      <= '0;
         ld_q      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         load_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  off_q     <= off;
                  f3_q      <= funct3;
                  ld_q      <= is_load;
                  load_data <= '0;
                  busy      <= 1'b1;
                  if (bad_f3 || misal) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {alu_result[WORD_BITWIDTH-1:2], 2'b00};
                     mem_wstrb <= is_store ? st_strb : '0;
                     mem_wdata <= is_store ? st_data : '0;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= '0;
                  if (ld_q)
                     load_data <= ext;
                  done  <= 1'b1;
                  err   <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: spec-level model checked every cycle,
// plus literal pins on key transactions.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] alu_result, store_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy, done, err;
   logic [31:0] load_data;

   lsu_mem_stage dut (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load),
      .is_store(is_store), .funct3(funct3), .alu_result(alu_result),
      .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
      .done(done), .err(err), .load_data(load_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit          chk_en;
   bit          e_req, e_busy, e_done, e_err, e_we;
   logic [31:0] e_addr, e_wdata, e_ld;
   logic [3:0]  e_wstrb;
   logic [31:0] ld_model;
   int          exp_dones = 0;

   int          dones = 0;
   int          done_cyc, acc_cyc, req_n;
   logic [31:0] last_ld, last_addr, last_wdata;
   logic [3:0]  last_wstrb;
   logic        last_err, last_we;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit legal(input bit ld, input logic [2:0] f3,
                                input logic [31:0] a);
      int sz;
      if (ld) begin
         if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
      end else if (f3 > 2) return 0;
      sz = 1 << f3[1:0];
      return (int'(a[1:0]) % sz) == 0;
   endfunction

   function automatic logic [31:0] ldval(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
      logic [31:0] w, b;
      w = rd >> (8 * int'(a[1:0]));
      case (f3)
         3'd0: begin b = w & 32'hFF; return (b >= 128) ? b + 32'hFFFFFF00 : b; end
         3'd4: return w & 32'hFF;
         3'd1: begin b = w & 32'hFFFF; return (b >= 32768) ? b + 32'hFFFF0000 : b; end
         3'd5: return w & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] strb(input logic [2:0] f3,
                                       input logic [31:0] a);
      int m;
      m = ((1 << (1 << f3[1:0])) - 1) << int'(a[1:0]);
      return m[3:0];
   endfunction

   function automatic logic [31:0] wdat(input logic [2:0] f3,
                                        input logic [31:0] sd);
      logic [31:0] r;
      int sz;
      sz = 1 << f3[1:0];
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
      return r;
   endfunction

   always @(negedge clk) if (chk_en) begin
      chk("req", mem_req, e_req);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("load_data", load_data, e_ld);
      if (e_done) chk("err", err, e_err);
      if (e_req) begin
         chk("we", mem_we, e_we);
         chk("addr", mem_addr, e_addr);
         chk("wstrb", mem_wstrb, e_wstrb);
         if (e_we) chk("wdata", mem_wdata, e_wdata);
      end
      if (mem_req) begin
         req_n++;
         last_addr = mem_addr; last_wstrb = mem_wstrb;
         last_wdata = mem_wdata; last_we = mem_we;
      end
      if (done) begin
         dones++; done_cyc = cyc; last_ld = load_data; last_err = err;
      end
   end

   task automatic idle_exp();
      e_req = 0; e_busy = 0; e_done = 0; e_err = 0; e_ld = ld_model;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rd, input int waitn,
                     input bit pulse);
      start = 1; is_load = ld; is_store = st; funct3 = f3;
      alu_result = a; store_data = sd; mem_rdata = rd; mem_ready = 0;
      idle_exp();
      acc_cyc = cyc; req_n = 0;
      step();
      start = 0; is_load = 0; is_store = 0;
      if (ld == st) begin
         idle_exp(); step(); step();
         return;
      end
      ld_model = 0; exp_dones++;
      if (!legal(ld, f3, a)) begin
         e_req = 0; e_busy = 1; e_done = 1; e_err = 1; e_ld = 0;
         step();
         idle_exp(); step();
         return;
      end
      e_req = 1; e_busy = 1; e_done = 0; e_we = st; e_ld = 0;
      e_addr = {a[31:2], 2'b00};
      e_wstrb = st ? strb(f3, a) : 4'h0;
      e_wdata = wdat(f3, sd);
      for (int i = 0; i <= waitn; i++) begin
         start = pulse && i == 1; is_load = pulse && i == 1;
         mem_ready = (i == waitn);
         step();
      end
      start = 0; is_load = 0; mem_ready = 0;
      if (ld) ld_model = ldval(f3, a, rd);
      e_req = 0; e_done = 1; e_err = 0; e_busy = 1; e_ld = ld_model;
      step();
      idle_exp();
      mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
      step();
      mem_ready = 0;
      step();
   endtask

   initial begin
      rst = 1; start = 0; is_load = 0; is_store = 0; funct3 = 0;
      alu_result = 0; store_data = 0; mem_ready = 0; mem_rdata = 0;
      ld_model = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      idle_exp(); chk_en = 1;
      step(); step();
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst = 0;
      step();

      op(1, 0, 3'd2, 32'h1000, 0, 32'hDEADBEEF, 0, 0);
      chk("lw_val", last_ld, 32'hDEADBEEF);
      chk("lw_lat", done_cyc - acc_cyc, 2);
      chk("lw_reqn", req_n, 1);
      chk("lw_addr", last_addr, 32'h1000);
      chk("lw_strb", last_wstrb, 4'h0);

      op(1, 0, 3'd0, 32'h2003, 0, 32'h80FF1234, 0, 0);
      chk("lb_val", last_ld, 32'hFFFFFF80);
      op(1, 0, 3'd4, 32'h2003, 0, 32'h80FF1234, 0, 0);
      chk("lbu_val", last_ld, 32'h00000080);
      op(1, 0, 3'd1, 32'h2002, 0, 32'h80FF1234, 0, 0);
      chk("lh_val", last_ld, 32'hFFFF80FF);
      op(1, 0, 3'd5, 32'h2002, 0, 32'h80FF1234, 1, 0);
      op(1, 0, 3'd0, 32'h2001, 0, 32'h80FF1234, 0, 0);

      op(0, 1, 3'd1, 32'h1002, 32'h1234ABCD, 0, 0, 0);
      chk("sh_we", last_we, 1);
      chk("sh_addr", last_addr, 32'h1000);
      chk("sh_strb", last_wstrb, 4'b1100);
      chk("sh_data", last_wdata, 32'hABCDABCD);
      chk("st_ld0", last_ld, 32'h0);
      op(0, 1, 3'd0, 32'h1001, 32'h000000EE, 0, 0, 0);
      chk("sb_strb", last_wstrb, 4'b0010);
      chk("sb_data", last_wdata, 32'hEEEEEEEE);
      op(0, 1, 3'd2, 32'h1004, 32'hCAFEF00D, 0, 2, 0);

      op(1, 0, 3'd2, 32'h1001, 0, 32'h11111111, 0, 0);
      chk("mis_lw_err", last_err, 1);
      chk("mis_lw_lat", done_cyc - acc_cyc, 1);
      chk("mis_lw_reqn", req_n, 0);
      chk("mis_lw_ld", last_ld, 0);
      op(0, 1, 3'd1, 32'h1003, 32'h5555, 0, 0, 0);
      chk("mis_sh_err", last_err, 1);
      op(1, 0, 3'd3, 32'h1000, 0, 32'h22222222, 0, 0);
      chk("ill_ld_err", last_err, 1);
      chk("ill_ld_reqn", req_n, 0);
      op(0, 1, 3'd4, 32'h1000, 32'h77, 0, 0, 0);
      chk("ill_st_err", last_err, 1);

      op(1, 0, 3'd2, 32'h4008, 0, 32'h0BADF00D, 3, 1);
      chk("wait_lat", done_cyc - acc_cyc, 5);
      chk("wait_reqn", req_n, 4);
      chk("wait_val", last_ld, 32'h0BADF00D);

      op(0, 0, 3'd2, 32'h1000, 0, 0, 0, 0);
      op(1, 1, 3'd2, 32'h1000, 0, 0, 0, 0);

      start = 1; is_load = 1; funct3 = 3'd2; alu_result = 32'h3000;
      idle_exp(); step();
      start = 0; is_load = 0; ld_model = 0;
      e_req = 1; e_busy = 1; e_done = 0; e_we = 0; e_ld = 0;
      e_addr = 32'h3000; e_wstrb = 0;
      step();
      chk_en = 0;
      #2 rst = 1;
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      step();
      rst = 0; idle_exp(); chk_en = 1;
      step();
      op(1, 0, 3'd2, 32'h3000, 0, 32'h12345678, 0, 0);
      chk("post_rst_val", last_ld, 32'h12345678);
      chk("post_rst_lat", done_cyc - acc_cyc, 2);

      chk("done_count", dones, exp_dones);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
